// File: rtl/alu_pkg.sv
// Shared widths and func_sel opcode constants for the ALU and its subtractor.
package alu_pkg;
    localparam int XW = 17;
    localparam int YW = 8;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd10;
    localparam logic [3:0] OP_DEC  = 4'd11;
    localparam logic [3:0] OP_CMP  = 4'd12;
    localparam logic [3:0] OP_CLR  = 4'd13;
endpackage

// File: rtl/alu_subt.sv
// Combinational subtractor S = A - zext(B), built as A + ~zext(B) + 1.
module subt
    import alu_pkg::*;
(
    input  logic [XW-1:0] A,
    input  logic [YW-1:0] B,
    output logic [XW-1:0] S,
    output logic          Cout,
    output logic          Bo,
    output logic          eqz
);
    logic [XW-1:0] b_ext;
    logic [XW:0]   sum;

    assign b_ext = {{(XW-YW){1'b0}}, B};
    // Cout=1 means no borrow: A >= zext(B).
    assign sum   = {1'b0, A} + {1'b0, ~b_ext} + {{XW{1'b0}}, 1'b1};
    assign S     = sum[XW-1:0];
    assign Cout  = sum[XW];
    assign Bo    = ~sum[XW];
    assign eqz   = (sum[XW-1:0] == '0);
endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU: result and flags update on the edge that samples operands.
module alu
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] X,
    input  logic [YW-1:0] Y,
    input  logic [3:0]    func_sel,
    output logic [XW-1:0] Z,
    output logic          Bo,
    output logic          eqz
);
    logic [XW-1:0] y_ext;
    logic [XW:0]   add_sum;
    logic [XW:0]   inc_sum;
    logic [XW-1:0] sub_s;
    logic          sub_cout;
    logic          sub_bo;
    logic          sub_eqz;
    logic [XW-1:0] z_next;
    logic          bo_next;
    logic          eqz_next;

    assign y_ext   = {{(XW-YW){1'b0}}, Y};
    assign add_sum = {1'b0, X} + {1'b0, y_ext};
    assign inc_sum = {1'b0, X} + {{XW{1'b0}}, 1'b1};

    subt u_subt (
        .A    (X),
        .B    (Y),
        .S    (sub_s),
        .Cout (sub_cout),
        .Bo   (sub_bo),
        .eqz  (sub_eqz)
    );

    always_comb begin
        z_next   = Z;
        bo_next  = Bo;
        eqz_next = eqz;
        unique case (func_sel)
            OP_LOAD: begin z_next = X;                 bo_next = 1'b0;          end
            OP_ADD:  begin z_next = add_sum[XW-1:0];   bo_next = add_sum[XW];   end
            OP_SUB:  begin z_next = sub_s;             bo_next = sub_bo;        end
            OP_SHL:  begin z_next = {X[XW-2:0], 1'b0}; bo_next = X[XW-1];       end
            OP_SHR:  begin z_next = {1'b0, X[XW-1:1]}; bo_next = X[0];          end
            OP_AND:  begin z_next = X & y_ext;         bo_next = 1'b0;          end
            OP_OR:   begin z_next = X | y_ext;         bo_next = 1'b0;          end
            OP_XOR:  begin z_next = X ^ y_ext;         bo_next = 1'b0;          end
            OP_NOT:  begin z_next = ~X;                bo_next = 1'b0;          end
            OP_INC:  begin z_next = inc_sum[XW-1:0];   bo_next = inc_sum[XW];   end
            OP_DEC:  begin z_next = X - {{(XW-1){1'b0}}, 1'b1}; bo_next = (X == '0); end
            OP_CLR:  begin z_next = '0;                bo_next = 1'b0;          end
            default: ;
        endcase
        // Zero flag follows the new result, except CMP which flags X == zext(Y).
        if (func_sel == OP_CMP) begin
            bo_next  = sub_bo;
            eqz_next = sub_eqz;
        end else if (func_sel == OP_SUB) begin
            eqz_next = sub_eqz;
        end else if (func_sel != OP_NOP && func_sel < 4'd14) begin
            eqz_next = (z_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            Z   <= '0;
            Bo  <= 1'b0;
            eqz <= 1'b1;
        end else begin
            Z   <= z_next;
            Bo  <= bo_next;
            eqz <= eqz_next;
        end
    end

    logic unused_cout;
    assign unused_cout = sub_cout;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU and a standalone subtractor instance.
module tb_alu;
    import alu_pkg::*;

    logic          clk;
    logic          rst;
    logic [XW-1:0] X;
    logic [YW-1:0] Y;
    logic [3:0]    func_sel;
    logic [XW-1:0] Z;
    logic          Bo;
    logic          eqz;

    logic [XW-1:0] sa;
    logic [YW-1:0] sb;
    logic [XW-1:0] ss;
    logic          scout;
    logic          sbo;
    logic          seqz;

    int n_vec = 0;
    int n_err = 0;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .X        (X),
        .Y        (Y),
        .func_sel (func_sel),
        .Z        (Z),
        .Bo       (Bo),
        .eqz      (eqz)
    );

    subt u_subt_sa (
        .A    (sa),
        .B    (sb),
        .S    (ss),
        .Cout (scout),
        .Bo   (sbo),
        .eqz  (seqz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, then look at outputs 1 time unit after the rising edge.
    task automatic step(input logic r, input logic [3:0] op, input logic [XW-1:0] x, input logic [YW-1:0] y);
        @(negedge clk);
        rst      = r;
        func_sel = op;
        X        = x;
        Y        = y;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [XW-1:0] ez, input logic ebo, input logic eeqz);
        n_vec++;
        assert ({Z, Bo, eqz} === {ez, ebo, eeqz}) else begin
            n_err++;
            $error("FAIL %s: got Z=%05h Bo=%b eqz=%b, want Z=%05h Bo=%b eqz=%b",
                   tag, Z, Bo, eqz, ez, ebo, eeqz);
        end
    endtask

    initial begin
        rst = 1'b1; func_sel = OP_NOP; X = '0; Y = '0;
        sa = '0; sb = '0;

        step(1'b0, OP_ADD, 17'h00005, 8'h00); check("reset", 17'h00000, 1'b0, 1'b1);

        step(1'b1, OP_SUB, 17'h00008, 8'h01); check("sub_8_1", 17'h00007, 1'b0, 1'b0);
        sa = 17'h00008; sb = 8'h01; #1;
        n_vec++;
        assert ({ss, scout, sbo, seqz} === {17'h00007, 1'b1, 1'b0, 1'b0}) else begin
            n_err++;
            $error("FAIL subt_standalone: got S=%05h Cout=%b Bo=%b eqz=%b, want S=00007 Cout=1 Bo=0 eqz=0",
                   ss, scout, sbo, seqz);
        end

        step(1'b1, OP_SUB, 17'h00001, 8'h02); check("sub_wrap", 17'h1FFFF, 1'b1, 1'b0);
        step(1'b1, OP_SUB, 17'h00005, 8'h05); check("sub_equal", 17'h00000, 1'b0, 1'b1);
        step(1'b1, OP_ADD, 17'h00001, 8'h02); check("add_1_2", 17'h00003, 1'b0, 1'b0);
        step(1'b1, OP_NOP, 17'h1ABCD, 8'h77); check("nop_hold", 17'h00003, 1'b0, 1'b0);
        step(1'b1, 4'd14,  17'h00000, 8'h00); check("op14_hold", 17'h00003, 1'b0, 1'b0);
        step(1'b1, 4'd15,  17'h1FFFF, 8'hFF); check("op15_hold", 17'h00003, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 17'h1FFFF, 8'h01); check("add_carry", 17'h00000, 1'b1, 1'b1);
        step(1'b1, OP_SHL, 17'h10001, 8'h00); check("shl_out1", 17'h00002, 1'b1, 1'b0);
        step(1'b1, OP_SHL, 17'h0FFFF, 8'h00); check("shl_out0", 17'h1FFFE, 1'b0, 1'b0);
        step(1'b1, OP_SHR, 17'h00003, 8'h00); check("shr_out1", 17'h00001, 1'b1, 1'b0);
        step(1'b1, OP_SHR, 17'h10000, 8'h00); check("shr_out0", 17'h08000, 1'b0, 1'b0);

        step(1'b1, OP_LOAD, 17'h00123, 8'h00); check("load_123", 17'h00123, 1'b0, 1'b0);
        step(1'b1, OP_CMP,  17'h00005, 8'h05); check("cmp_eq", 17'h00123, 1'b0, 1'b1);
        step(1'b1, OP_LOAD, 17'h00123, 8'h00); check("load_123b", 17'h00123, 1'b0, 1'b0);
        step(1'b1, OP_CMP,  17'h00004, 8'h05); check("cmp_lt", 17'h00123, 1'b1, 1'b0);

        step(1'b1, OP_AND, 17'h1F0F0, 8'h3C); check("and", 17'h00030, 1'b0, 1'b0);
        step(1'b1, OP_OR,  17'h10000, 8'h0F); check("or", 17'h1000F, 1'b0, 1'b0);
        step(1'b1, OP_XOR, 17'h000FF, 8'hFF); check("xor_zero", 17'h00000, 1'b0, 1'b1);
        step(1'b1, OP_NOT, 17'h1FFFF, 8'h00); check("not_ones", 17'h00000, 1'b0, 1'b1);
        step(1'b1, OP_NOT, 17'h00000, 8'h00); check("not_zero", 17'h1FFFF, 1'b0, 1'b0);
        step(1'b1, OP_INC, 17'h1FFFF, 8'h00); check("inc_wrap", 17'h00000, 1'b1, 1'b1);
        step(1'b1, OP_INC, 17'h00005, 8'h00); check("inc_5", 17'h00006, 1'b0, 1'b0);
        step(1'b1, OP_DEC, 17'h00000, 8'h00); check("dec_wrap", 17'h1FFFF, 1'b1, 1'b0);
        step(1'b1, OP_DEC, 17'h00001, 8'h00); check("dec_1", 17'h00000, 1'b0, 1'b1);
        step(1'b1, OP_LOAD, 17'h00007, 8'h00); check("load_7", 17'h00007, 1'b0, 1'b0);
        step(1'b1, OP_CLR, 17'h1FFFF, 8'hFF); check("clr", 17'h00000, 1'b0, 1'b1);

        step(1'b1, OP_LOAD, 17'h00055, 8'h00); check("load_55", 17'h00055, 1'b0, 1'b0);
        step(1'b0, OP_ADD,  17'h1FFFF, 8'h01); check("mid_reset", 17'h00000, 1'b0, 1'b1);
        step(1'b1, OP_LOAD, 17'h00009, 8'h00); check("after_reset", 17'h00009, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
- REQ-001: Parameter XW, default 17, operand-X/result width; fixed at 17 for this block.
- REQ-002: Parameter YW, default 8, operand-Y width; fixed at 8 for this block.
- REQ-003: One clock; reset is synchronous and active-low.
- REQ-004: clk  input  1  sole clock; all state updates on rising edge.
- REQ-005: rst  input  1  synchronous active-low reset.
- REQ-006: X  input  17  operand A, unsigned.
- REQ-007: Y  input  8  operand B, unsigned, zero-extended to 17 bits before use.
- REQ-008: func_sel  input  4  operation select.
- REQ-009: Z  output  17  registered result.
- REQ-010: Bo  output  1  registered carry/borrow/shift-out flag.
- REQ-011: eqz  output  1  registered zero/equal flag.

Function
- REQ-012: Outputs SHALL be registered with 1-cycle latency: operands and func_sel sampled at a rising edge appear on Z/Bo/eqz immediately after that edge.
- REQ-013: No handshake; a new operation is accepted every cycle.
- REQ-014: func_sel encoding SHALL be:
  - 0 NOP: Z, Bo, eqz hold.
  - 1 LOAD: Z=X.
  - 2 ADD: Z=X+Y.
  - 3 SUB: Z=X-Y.
  - 4 SHL: Z=X<<1.
  - 5 SHR: Z=X>>1 (logical).
  - 6 AND: Z=X&Y.
  - 7 OR: Z=X|Y.
  - 8 XOR: Z=X^Y.
  - 9 NOT: Z=~X.
  - 10 INC: Z=X+1.
  - 11 DEC: Z=X-1.
  - 12 CMP: Z holds.
  - 13 CLR: Z=0.
  - 14, 15: behave as NOP.
- REQ-015: All arithmetic SHALL be modulo 2^17; Z wraps (0x1FFFF+1 gives 0, 0-1 gives 0x1FFFF).
- REQ-016: Bo SHALL be:
  - ADD/INC: carry out of bit 16.
  - SUB/DEC/CMP: borrow, i.e. 1 when the minuend is less than the subtrahend.
  - SHL: old X[16].
  - SHR: old X[0].
  - All other non-NOP ops: 0.
- REQ-017: eqz SHALL be 1 when the new Z is zero; for CMP, eqz SHALL be 1 when X equals zero-extended Y.
- REQ-018: SUB and CMP SHALL use the subt sub-module's outputs for Z, Bo and eqz.

Reset
- REQ-019: When rst=0 at a rising edge: Z=0, Bo=0, eqz=1, overriding any func_sel.
- REQ-020: Reset asserted mid-stream SHALL discard the operation of that cycle; the first operation after rst returns to 1 is the one sampled at the first edge with rst=1.

Structure
- REQ-021: A shared package SHALL hold XW, YW and the func_sel opcode constants (OP_NOP…OP_CLR).
- REQ-022: One combinational sub-module subt SHALL be instantiated with ports:
  - A[16:0], B[7:0] inputs.
  - S[16:0]=A-zext(B).
  - Cout = carry of A+~B+1.
  - Bo = ~Cout.
  - eqz = (S==0).
- REQ-023: The alu SHALL contain no state other than the Z/Bo/eqz registers.

Verification
- REQ-024: rst=0 for one edge with X=5, func_sel=2 -> Z=0, Bo=0, eqz=1.
- REQ-025: SUB, X=0x00008, Y=0x01 -> next edge Z=0x00007, Bo=0, eqz=0; subt standalone gives S=7, Cout=1.
- REQ-026: SUB, X=1, Y=2 -> Z=0x1FFFF, Bo=1, eqz=0.
- REQ-027: ADD, X=1, Y=2 -> Z=3, Bo=0; then ADD, X=0x1FFFF, Y=1 -> Z=0, Bo=1, eqz=1.
- REQ-028: Shift checks:
  - SHL, X=0x10001 -> Z=0x00002, Bo=1.
  - SHR, X=0x00003 -> Z=0x00001, Bo=1.
- REQ-029: CMP checks, each from Z=0x00123:
  - CMP, X=5, Y=5 -> Z stays 0x00123, eqz=1, Bo=0.
  - CMP, X=4, Y=5 -> Z stays 0x00123, eqz=0, Bo=1.
- REQ-030: NOP after ADD result 3 -> Z=3 and flags unchanged.
